apb_master_err: RTL and testbench

- APB requester that drives the same APB slave interface as apb_slave_error: 32-bit paddr, 8-bit pwdata/prdata, pready, pslverr.
- Accepts one command at a time from a local valid/ready command port and runs it as an APB SETUP→ACCESS transfer, honouring pready wait states.
- Returns read data plus error status on a one-cycle response strobe.
- Adds a wait-state timeout and a saturating error counter, so a hung or erroring slave cannot stall the system silently.

---
 rtl/apb_master_err_if.sv | 59 +++++
 rtl/apb_master_err.sv | 136 +++++++++++++
 tb/tb_apb_master_err.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_master_err_if.sv
// Bundle of the local command/response port and the APB requester bus.
// The "master" modport is the view of the APB requester itself. The "slave"
// modport is the view of the environment: the command source, the response
// sink and the APB completer.
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both 1. cmd_valid may be raised at any time. cmd_ready does
// not depend on cmd_valid. rsp_valid is a one-cycle strobe with no
// back-pressure, and the rsp_* fields hold until the next completion.
interface apb_master_err_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
);
    // local command port
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    // local response port
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;
    logic [CNT_W-1:0]  err_count;

    // APB requester signals
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    // FSM state for observation (0=IDLE, 1=SETUP, 2=ACCESS)
    logic [1:0]        dbg_state;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  prdata, pready, pslverr,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout, err_count,
        output psel, penable, pwrite, paddr, pwdata,
        output dbg_state
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output prdata, pready, pslverr,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout, err_count,
        input  psel, penable, pwrite, paddr, pwdata,
        input  dbg_state
    );
endinterface

// File: rtl/apb_master_err.sv
// APB requester with a single outstanding command. Each accepted command is
// run as one SETUP -> ACCESS transfer. pready wait states are honoured, and
// the transfer is aborted after TIMEOUT ACCESS cycles with pready low
// (TIMEOUT=0 disables the abort). Every completion pulses rsp_valid once and
// updates the held rsp_* fields. A saturating counter records how many
// completions were errors.
module apb_master_err #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic             pclk,
    input  logic             presetn,
    apb_master_err_if.master bus
);

    // Wait counter only needs to reach TIMEOUT-1.
    localparam int WC_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WC_W-1:0] WC_LAST = (TIMEOUT > 0) ? WC_W'(TIMEOUT - 1) : '0;
    localparam logic TIMEOUT_ON = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_psel;
    logic              r_penable;
    logic              r_pwrite;
    logic [ADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0] r_pwdata;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_rsp_err;
    logic              r_rsp_timeout;
    logic [CNT_W-1:0]  r_err_count;
    logic [WC_W-1:0]   r_wait_cnt;

    logic              w_cmd_ready;
    logic              w_timeout_hit;
    logic              w_cnt_sat;

    // Ready whenever idle, including while reset is held. The reset branch
    // below keeps a command from being taken during reset.
    assign w_cmd_ready   = (r_state == ST_IDLE);
    // Last permitted wait cycle has been reached.
    assign w_timeout_hit = TIMEOUT_ON && (r_wait_cnt == WC_LAST);
    // Error counter is at its all-ones ceiling.
    assign w_cnt_sat     = &r_err_count;

    // Transfer sequencer: IDLE -> SETUP (one cycle) -> ACCESS (until pready or timeout).
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state       <= ST_IDLE;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_paddr       <= '0;
            r_pwdata      <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_err_count   <= '0;
            r_wait_cnt    <= '0;
        end else begin
            // The response strobe is one cycle wide. The other rsp_* fields hold.
            r_rsp_valid <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        r_pwrite  <= bus.cmd_write;
                        r_paddr   <= bus.cmd_addr;
                        r_pwdata  <= bus.cmd_wdata;
                        r_psel    <= 1'b1;
                        r_penable <= 1'b0;
                        r_state   <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    r_penable  <= 1'b1;
                    r_wait_cnt <= '0;
                    r_state    <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    // pready wins over the timeout when both occur on the same edge.
                    if (bus.pready) begin
                        r_rsp_valid   <= 1'b1;
                        r_rsp_err     <= bus.pslverr;
                        r_rsp_rdata   <= r_pwrite ? '0 : bus.prdata;
                        r_rsp_timeout <= 1'b0;
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_state       <= ST_IDLE;
                        if (bus.pslverr && !w_cnt_sat) begin
                            r_err_count <= r_err_count + CNT_W'(1);
                        end
                    end else if (w_timeout_hit) begin
                        r_rsp_valid   <= 1'b1;
                        r_rsp_err     <= 1'b1;
                        r_rsp_rdata   <= '0;
                        r_rsp_timeout <= 1'b1;
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_state       <= ST_IDLE;
                        if (!w_cnt_sat) begin
                            r_err_count <= r_err_count + CNT_W'(1);
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WC_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready   = w_cmd_ready;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_rdata   = r_rsp_rdata;
    assign bus.rsp_err     = r_rsp_err;
    assign bus.rsp_timeout = r_rsp_timeout;
    assign bus.err_count   = r_err_count;
    assign bus.psel        = r_psel;
    assign bus.penable     = r_penable;
    assign bus.pwrite      = r_pwrite;
    assign bus.paddr       = r_paddr;
    assign bus.pwdata      = r_pwdata;
    assign bus.dbg_state   = r_state;

endmodule

// File: tb/tb_apb_master_err.sv
// Bench for apb_master_err. The bench plays both the command source and a
// 16-entry APB completer. Addresses above 15 return pslverr=1 and prdata=0.
// The expected bus and response values are kept as a timeline per
// transaction: psel is high for 1 + ACCESS cycles, penable for the ACCESS
// cycles, and the response appears in the cycle after the ending edge. A
// single negedge process compares every output against that expectation.
module tb_apb_master_err;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic pclk    = 1'b0;
    logic presetn = 1'b0;

    apb_master_err_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    apb_master_err #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .pclk   (pclk),
        .presetn(presetn),
        .bus    (bus)
    );

    // clock
    always #5 pclk = ~pclk;

    // expected outputs
    logic        exp_cmd_ready   = 1'b1;
    logic        exp_psel        = 1'b0;
    logic        exp_penable     = 1'b0;
    logic        exp_pwrite      = 1'b0;
    logic [31:0] exp_paddr       = '0;
    logic [7:0]  exp_pwdata      = '0;
    logic        exp_rsp_valid   = 1'b0;
    logic [7:0]  exp_rsp_rdata   = '0;
    logic        exp_rsp_err     = 1'b0;
    logic        exp_rsp_timeout = 1'b0;
    int          exp_err_count   = 0;

    // completer memory
    logic [7:0] mem [16];

    int total = 0;
    int bad   = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endfunction

    // per-cycle comparison against the expectation
    always @(negedge pclk) begin
        chk("cmd_ready",   32'(bus.cmd_ready),   32'(exp_cmd_ready));
        chk("psel",        32'(bus.psel),        32'(exp_psel));
        chk("penable",     32'(bus.penable),     32'(exp_penable));
        chk("pwrite",      32'(bus.pwrite),      32'(exp_pwrite));
        chk("paddr",       bus.paddr,            exp_paddr);
        chk("pwdata",      32'(bus.pwdata),      32'(exp_pwdata));
        chk("rsp_valid",   32'(bus.rsp_valid),   32'(exp_rsp_valid));
        chk("rsp_rdata",   32'(bus.rsp_rdata),   32'(exp_rsp_rdata));
        chk("rsp_err",     32'(bus.rsp_err),     32'(exp_rsp_err));
        chk("rsp_timeout", 32'(bus.rsp_timeout), 32'(exp_rsp_timeout));
        chk("err_count",   32'(bus.err_count),   32'(exp_err_count));
    end

    // Advance one cycle and land just after the edge. The completer lines are
    // randomised by default; during ACCESS the transaction driver overrides them.
    task automatic step();
        @(posedge pclk);
        #1;
        exp_rsp_valid = 1'b0;
        bus.pready    = 1'($urandom_range(0, 1));
        bus.pslverr   = 1'($urandom_range(0, 1));
        bus.prdata    = 8'($urandom);
    endtask

    function automatic void set_reset_expect();
        exp_cmd_ready   = 1'b1;
        exp_psel        = 1'b0;
        exp_penable     = 1'b0;
        exp_pwrite      = 1'b0;
        exp_paddr       = '0;
        exp_pwdata      = '0;
        exp_rsp_valid   = 1'b0;
        exp_rsp_rdata   = '0;
        exp_rsp_err     = 1'b0;
        exp_rsp_timeout = 1'b0;
        exp_err_count   = 0;
    endfunction

    // Present a command and act as the completer. waits = number of ACCESS
    // cycles with pready low before it rises. Any value >= TIMEOUT means
    // pready never rises. noisy drives pslverr=1 during the wait cycles.
    task automatic run_txn(input bit wr, input logic [31:0] a, input logic [7:0] d,
                           input int waits, input bit noisy);
        bit to;
        bit err;
        int acc;
        to  = (waits >= TIMEOUT);
        acc = to ? TIMEOUT : waits + 1;
        err = (a > 32'd15);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        step();
        // SETUP cycle. The command lines now carry junk.
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'($urandom);
        bus.cmd_addr  = 32'($urandom);
        bus.cmd_wdata = 8'($urandom);
        exp_cmd_ready = 1'b0;
        exp_psel      = 1'b1;
        exp_penable   = 1'b0;
        exp_pwrite    = wr;
        exp_paddr     = a;
        exp_pwdata    = d;
        for (int j = 0; j < acc; j++) begin
            step();
            exp_penable = 1'b1;
            if (!to && j == waits) begin
                bus.pready  = 1'b1;
                bus.pslverr = err;
                bus.prdata  = wr ? 8'($urandom) : (err ? 8'h00 : mem[a[3:0]]);
            end else begin
                bus.pready  = 1'b0;
                bus.pslverr = noisy ? 1'b1 : 1'($urandom_range(0, 1));
                bus.prdata  = 8'($urandom);
            end
        end
        step();
        // cycle after the ending edge
        exp_cmd_ready = 1'b1;
        exp_psel      = 1'b0;
        exp_penable   = 1'b0;
        exp_rsp_valid = 1'b1;
        if (to) begin
            exp_rsp_rdata   = 8'h00;
            exp_rsp_err     = 1'b1;
            exp_rsp_timeout = 1'b1;
        end else begin
            exp_rsp_err     = err;
            exp_rsp_timeout = 1'b0;
            exp_rsp_rdata   = (wr || err) ? 8'h00 : mem[a[3:0]];
            if (wr && !err) mem[a[3:0]] = d;
        end
        if (to || err) exp_err_count = (exp_err_count >= CNT_MAX) ? CNT_MAX : exp_err_count + 1;
    endtask

    // watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

    int sat_seq [5] = '{1, 2, 3, 3, 3};

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.pready    = 1'b0;
        bus.pslverr   = 1'b0;
        bus.prdata    = '0;
        for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
        set_reset_expect();

        // reset
        repeat (3) step();
        presetn = 1'b1;
        chk("reset_psel", 32'(bus.psel), 32'd0);
        chk("reset_cnt",  32'(bus.err_count), 32'd0);

        // write then read back, zero wait states, back to back
        run_txn(1'b1, 32'd3, 8'hA5, 0, 1'b0);
        chk("wr3_err", 32'(bus.rsp_err), 32'd0);
        run_txn(1'b0, 32'd3, 8'h11, 0, 1'b0);
        chk("rd3_rdata", 32'(bus.rsp_rdata), 32'hA5);
        chk("rd3_err",   32'(bus.rsp_err), 32'd0);

        // erroring write and read
        run_txn(1'b1, 32'd20, 8'h3C, 0, 1'b0);
        chk("wr20_err", 32'(bus.rsp_err), 32'd1);
        chk("wr20_to",  32'(bus.rsp_timeout), 32'd0);
        chk("wr20_cnt", 32'(bus.err_count), 32'd1);
        run_txn(1'b0, 32'd200, 8'h00, 1, 1'b0);
        chk("rd200_err",   32'(bus.rsp_err), 32'd1);
        chk("rd200_rdata", 32'(bus.rsp_rdata), 32'd0);
        chk("rd200_cnt",   32'(bus.err_count), 32'd2);

        // three wait states with pslverr asserted while pready is low
        run_txn(1'b0, 32'd5, 8'h77, 3, 1'b1);
        chk("rd5_wait_err", 32'(bus.rsp_err), 32'd0);

        // timeout, then pready on exactly the last permitted edge
        step();
        run_txn(1'b0, 32'd9, 8'h00, 99, 1'b0);
        chk("to_flag", 32'(bus.rsp_timeout), 32'd1);
        chk("to_err",  32'(bus.rsp_err), 32'd1);
        chk("to_cnt",  32'(bus.err_count), 32'd3);
        run_txn(1'b1, 32'd9, 8'hC3, TIMEOUT - 1, 1'b0);
        chk("edge_to",  32'(bus.rsp_timeout), 32'd0);
        chk("edge_err", 32'(bus.rsp_err), 32'd0);

        // reset asserted during ACCESS of a write to addr 7
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 32'd7;
        bus.cmd_wdata = 8'h5A;
        step();
        bus.cmd_valid = 1'b0;
        exp_cmd_ready = 1'b0;
        exp_psel      = 1'b1;
        exp_pwrite    = 1'b1;
        exp_paddr     = 32'd7;
        exp_pwdata    = 8'h5A;
        step();
        exp_penable   = 1'b1;
        bus.pready    = 1'b0;
        #2;
        presetn = 1'b0;
        set_reset_expect();
        #1;
        chk("midrst_psel",    32'(bus.psel), 32'd0);
        chk("midrst_penable", 32'(bus.penable), 32'd0);
        chk("midrst_paddr",   bus.paddr, 32'd0);
        chk("midrst_cnt",     32'(bus.err_count), 32'd0);
        step();
        step();
        presetn = 1'b1;
        step();
        run_txn(1'b1, 32'd7, 8'h42, 0, 1'b0);
        chk("post_rst_err", 32'(bus.rsp_err), 32'd0);

        // saturating counter
        for (int i = 0; i < 5; i++) begin
            run_txn(1'b1, 32'd300, 8'($urandom), 0, 1'b0);
            chk("sat_cnt", 32'(bus.err_count), 32'(sat_seq[i]));
        end

        // randomized traffic
        for (int n = 0; n < 80; n++) begin
            bit          wr;
            logic [31:0] a;
            int          r;
            int          waits;
            wr = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 9) == 0) ? 32'(16 + $urandom_range(0, 1000))
                                             : 32'($urandom_range(0, 15));
            r  = $urandom_range(0, 19);
            if (r < 14)      waits = r % 4;
            else if (r < 17) waits = TIMEOUT - 1;
            else             waits = TIMEOUT + r;
            run_txn(wr, a, 8'($urandom), waits, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) step();
        end
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
